// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the byte-serial addition sequencer.
// Holds the FSM state encoding, the byte width and the index-width helper.
// Imported by the sequencer and the 8-bit adder slice.
package adder_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the byte index; at least one bit so a 2-byte build still has a counter.
  function automatic int idx_width(input int nbytes);
    return (nbytes <= 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/adder_8.sv
// 8-bit carry-select adder slice: ripple low nibble, precomputed high nibble for both carries.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module adder_8
  import adder_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  // Low nibble ripples from cin; high nibble is computed for both possible carries
  // and the low-nibble carry picks one, keeping the slice short enough for one cycle.
  always_comb begin
    lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    hi0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    cout = lo[4] ? hi1[4] : hi0[4];
  end

endmodule

// File: rtl/adder_8_seq_ctrl.sv
// Wide adder that reuses one adder_8 slice, LSB byte first, carry held in a flop between bytes.
// Latency: NBYTES cycles from accept to out_valid; one request per NBYTES+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. Optional out_ovf under ADD_SEQ_OVF_EN.
module adder_8_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] in_a,
  input  logic [BYTE_W*NBYTES-1:0] in_b,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] out_sum,
  output logic                     out_cout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic                     out_ovf
`endif
);

  localparam int                 IDX_W    = idx_width(NBYTES);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NBYTES - 1);

  state_t state;
  state_t state_nxt;

  logic [NBYTES-1:0][BYTE_W-1:0] a_q;
  logic [NBYTES-1:0][BYTE_W-1:0] b_q;
  logic [NBYTES-1:0][BYTE_W-1:0] sum_q;
  logic                          carry_q;
  logic [IDX_W-1:0]              idx;
  logic                          cout_q;

  logic [BYTE_W-1:0] slice_a;
  logic [BYTE_W-1:0] slice_b;
  logic [BYTE_W-1:0] slice_sum;
  logic              slice_cout;

  logic accept;
  logic last_byte;

  assign accept    = in_valid && in_ready;
  assign last_byte = (state == RUN) && (idx == LAST_IDX);

  // Operand byte select feeding the shared slice; this mux is the critical path.
  assign slice_a = a_q[idx];
  assign slice_b = b_q[idx];

  adder_8 u_adder_8 (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, leave RUN on the top byte, release DONE on out_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: latch operands on accept, then write one result byte per RUN cycle.
  // Unwritten result bytes keep their old value; they are hidden while out_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_b;
      carry_q <= in_cin;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_q[idx] <= slice_sum;
      carry_q    <= slice_cout;
      if (last_byte) cout_q <= slice_cout;
      else           idx    <= idx + 1'b1;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

`ifdef ADD_SEQ_OVF_EN
  logic ovf_q;

  // Signed overflow from the top byte's sign bits, captured alongside the carry out.
  always_ff @(posedge clk) begin
    if (!rst_n)         ovf_q <= 1'b0;
    else if (last_byte) ovf_q <= (slice_a[BYTE_W-1] == slice_b[BYTE_W-1]) &&
                                 (slice_sum[BYTE_W-1] != slice_a[BYTE_W-1]);
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_8_seq_ctrl.sv
// Self-checking bench for adder_8_seq_ctrl (NBYTES=4): directed cases plus random operands.
// Expected results come from whole-word arithmetic, not byte-serial modelling.
// out_ovf is checked only when ADD_SEQ_OVF_EN is defined.
module tb_adder_8_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef ADD_SEQ_OVF_EN
  logic         out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  adder_8_seq_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef ADD_SEQ_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: present, accept, scramble inputs, time the latency,
  // check the result against whole-word arithmetic, optionally hold it under backpressure.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int hold);
    logic [W:0]   full;
    logic [W-1:0] held;
    logic         exp_ovf;
    int           cnt;
    full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    check("ready_before_accept", 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cin   = 1'($urandom);
    check("ready_low_in_run", 64'(in_ready), 64'(0));
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check("latency", 64'(cnt), 64'(NB));
    check("sum", 64'(out_sum), 64'(full[W-1:0]));
    check("cout", 64'(out_cout), 64'(full[W]));
`ifdef ADD_SEQ_OVF_EN
    check("ovf", 64'(out_ovf), 64'(exp_ovf));
`else
    if (exp_ovf) cnt = cnt;
`endif
    held = out_sum;
    if (hold > 0) in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_sum", 64'(out_sum), 64'(held));
      check("hold_cout", 64'(out_cout), 64'(full[W]));
      check("hold_no_accept", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    tick();
    check("valid_drop", 64'(out_valid), 64'(0));
    check("ready_after", 64'(in_ready), 64'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sum", 64'(out_sum), 64'(0));
    check("rst_out_cout", 64'(out_cout), 64'(0));
`ifdef ADD_SEQ_OVF_EN
    check("rst_out_ovf", 64'(out_ovf), 64'(0));
`endif

    // Carry ripples through every byte.
    do_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    check("ripple_sum", 64'(out_sum), 64'h0);
    check("ripple_cout", 64'(out_cout), 64'h1);
    do_add(32'h1234_5678, 32'h1111_1111, 1'b1, 0);
    check("plain_sum", 64'(out_sum), 64'h2345_678A);

    // Backpressure: result held for 5 cycles while a new request waits.
    do_add(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 5);
    check("bp_sum", 64'(out_sum), 64'h0);
    check("bp_cout", 64'(out_cout), 64'h1);
    do_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);

    // Reset in the first RUN cycle aborts the operation.
    in_valid = 1'b1;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h1234_4321;
    in_cin   = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_out_sum", 64'(out_sum), 64'(0));
    check("abort_out_cout", 64'(out_cout), 64'(0));
    do_add(32'h0000_0001, 32'h0000_0001, 1'b0, 0);
    check("after_abort_sum", 64'(out_sum), 64'h2);

    // Signed overflow corner cases.
    do_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    do_add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    do_add(32'h8000_0000, 32'h8000_0000, 1'b0, 1);

    // Random operands with random backpressure.
    for (int n = 0; n < 24; n++) begin
      do_add($urandom, $urandom, 1'($urandom), $urandom_range(0, 3));
    end

    in_valid = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_8_seq_ctrl.md
# adder_8_seq_ctrl

Multi-precision addition sequencer that time-multiplexes one `adder_8` slice to add two NBYTES-wide operands, least-significant byte first, over NBYTES cycles. The carry ripples between cycles through a registered carry flop. It sits between a valid/ready operand source and a valid/ready result sink. It lets wide additions reuse the 8-bit carry-select adder instead of instantiating a wide adder.

## Interface
- NBYTES, 4: operand width in bytes; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand source has a request.
- in_ready  output  1  block accepts a request; high only in IDLE.
- in_a  input  8*NBYTES  operand A.
- in_b  input  8*NBYTES  operand B.
- in_cin  input  1  carry into byte 0.
- out_valid  output  1  result held valid.
- out_ready  input  1  sink accepts the result.
- out_sum  output  8*NBYTES  sum, modulo 2^(8*NBYTES).
- out_cout  output  1  carry out of the top byte.
- out_ovf  output  1  signed overflow; present only with ADD_SEQ_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, in_ready=1: on in_valid, latch in_a, in_b and in_cin (into the carry flop), clear byte index idx to 0, go to RUN.
- RUN: `adder_8` sees byte idx of A and B and the carry flop. On each edge:
  - result byte is written to out_sum[8*idx +: 8];
  - carry flop takes the slice cout;
  - idx increments.
- When idx==NBYTES-1, that edge also moves the FSM to DONE and latches out_cout from the slice cout.
- DONE: out_valid=1. out_sum and out_cout are stable until out_ready=1. On out_valid&&out_ready, go to IDLE.
- in_ready is 0 in RUN and DONE. There are no back-to-back accepts; the minimum request period is NBYTES+2 cycles.
- Operand and carry changes on in_* after acceptance have no effect.
- idx width is clog2(NBYTES). idx never exceeds NBYTES-1, so it never wraps past the last byte.
- Reset mid-operation (RUN or DONE) aborts the operation with no result. Reset values:
  - state = IDLE;
  - in_ready = 1 on the first cycle after reset;
  - out_valid = 0;
  - out_sum = 0;
  - out_cout = 0;
  - out_ovf = 0;
  - carry flop = 0;
  - idx = 0.
- out_sum bytes not yet written during RUN hold their previous values. They are not observable because out_valid=0.

## Timing
- Accept edge T0 (in_valid&&in_ready).
- Byte k is written at edge T0+1+k.
- out_valid rises after edge T0+NBYTES. Latency from accept to out_valid is NBYTES cycles.
- out_valid falls on the edge where out_ready=1 is sampled. in_ready is high in the following cycle.
- out_ready held high before DONE: the result is consumed in the first DONE cycle, so out_valid is high for exactly one cycle.
- The `adder_8` path is combinational within one cycle. The only critical path is operand byte mux → slice → carry/sum flops.

## Configuration
- ADD_SEQ_OVF_EN defined: out_ovf port exists. It is latched at the final RUN edge as (A_msb == B_msb) && (sum_msb != A_msb), using bit 7 of the top byte. Same reset and hold rules as out_cout.
- ADD_SEQ_OVF_EN undefined: out_ovf port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Package adder_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - BYTE_W = 8;
  - a function computing idx width from NBYTES.
- One sub-module: the existing `adder_8`, instantiated once. No other hierarchy.

## Test plan
All scenarios use NBYTES=4 unless stated.
- Reset: assert rst_n=0 for 2 cycles, then release → in_ready=1, out_valid=0, out_sum=0, out_cout=0.
- A=0xFFFFFFFF, B=0x00000001, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x00000000, cout=1. Check the carry ripples through all bytes.
- A=0x12345678, B=0x11111111, cin=1 → sum=0x2345678A, cout=0.
- Backpressure: A=0xAAAAAAAA, B=0x55555555, cin=1, out_ready=0 for 5 cycles → out_valid high and sum=0x00000000, cout=1 held stable throughout. in_valid stays high and is not accepted until the cycle after out_ready.
- Reset mid-RUN: assert rst_n=0 during the cycle after accept → next cycle IDLE with all outputs at reset values. A following add of 0x00000001+0x00000001 gives 0x00000002.
- ADD_SEQ_OVF_EN: A=0x7FFFFFFF, B=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1. Then A=B=0xFFFFFFFF, cin=0 → sum=0xFFFFFFFE, cout=1, ovf=0.
